uart_word_rx: RTL

UART_WORD_RX -- requirements
Module: uart_word_rx

---
 rtl/uart_word_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_word_rx.sv
// UART receiver (8 data bits, 1 stop bit) that pairs accepted bytes into 16-bit words, low byte first.
// Define UART_WORD_RX_PARITY_EN to add an even-parity bit between data bit 7 and the stop bit.
module uart_word_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        rx_i,
  output logic [7:0]  rx_byte_o,
  output logic        rx_byte_valid_o,
  output logic [15:0] word_o,
  output logic        word_valid_o,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
`ifdef UART_WORD_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
`endif
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic             rx_meta_q, rx_sync_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ptr_q, ptr_d;
  logic [7:0]       low_q, low_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_valid_q, rx_byte_valid_d;
  logic [15:0]      word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q;
`ifdef UART_WORD_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Next-state and output decode; every frame sample is taken mid-bit.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shreg_d         = shreg_q;
    ptr_d           = ptr_q;
    low_d           = low_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    word_d          = word_q;
    word_valid_d    = 1'b0;
    frame_err_d     = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
    par_bit_d       = par_bit_q;
    parity_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_WORD_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_sync_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          // A bad stop bit outranks a parity mismatch; either one drops the half-built word.
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
            ptr_d       = 1'b0;
            low_d       = '0;
            state_d     = S_RECOVER;
          end
`ifdef UART_WORD_RX_PARITY_EN
          else if (par_bit_q != (^shreg_q)) begin
            parity_err_d = 1'b1;
            ptr_d        = 1'b0;
            low_d        = '0;
            state_d      = S_IDLE;
          end
`endif
          else begin
            state_d         = S_IDLE;
            rx_byte_d       = shreg_q;
            rx_byte_valid_d = 1'b1;
            if (!ptr_q) begin
              low_d = shreg_q;
              ptr_d = 1'b1;
            end else begin
              word_d       = {shreg_q, low_q};
              word_valid_d = 1'b1;
              ptr_d        = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shreg_q         <= '0;
      ptr_q           <= 1'b0;
      low_q           <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      word_q          <= '0;
      word_valid_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      busy_q          <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
      par_bit_q       <= 1'b0;
      parity_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q       <= rx_i;
      rx_sync_q       <= rx_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shreg_q         <= shreg_d;
      ptr_q           <= ptr_d;
      low_q           <= low_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      word_q          <= word_d;
      word_valid_q    <= word_valid_d;
      frame_err_q     <= frame_err_d;
      busy_q          <= (state_d != S_IDLE);
`ifdef UART_WORD_RX_PARITY_EN
      par_bit_q       <= par_bit_d;
      parity_err_q    <= parity_err_d;
`endif
    end
  end

  assign rx_byte_o       = rx_byte_q;
  assign rx_byte_valid_o = rx_byte_valid_q;
  assign word_o          = word_q;
  assign word_valid_o    = word_valid_q;
  assign frame_err_o     = frame_err_q;
  assign busy_o          = busy_q;
`ifdef UART_WORD_RX_PARITY_EN
  assign parity_err_o    = parity_err_q;
`else
  assign parity_err_o    = 1'b0;
`endif

endmodule
